// File: rtl/td4_pkg.sv
// Shared definitions for the TD4 sequencer: widths, opcodes, FSM states and
// the decoded control bundle passed from td4_decoder to the sequencer.
package td4_pkg;

  localparam int DATA_W  = 4;
  localparam int ADDR_W  = 4;
  localparam int INSTR_W = 8;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_A  = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_B  = 4'b0111;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_IM = 4'b1011;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  // Operand source: the same mux feeds the A/B write data and the output port.
  typedef enum logic [1:0] {
    SRC_IM = 2'd0,
    SRC_A  = 2'd1,
    SRC_B  = 2'd2,
    SRC_IN = 2'd3
  } src_e;

  typedef struct packed {
    logic wrA;
    logic wrB;
    src_e src;
    logic addEn;
    logic outEn;
    logic jump;
    logic jumpCond;
  } ctrl_t;

endpackage

// File: rtl/td4_sequencer_if.sv
// Bus between the TD4 sequencer and its environment (ROM, switches, debug).
// master = the sequencer, slave = whatever drives ROM data and controls.
interface td4_sequencer_if;
  import td4_pkg::*;

  logic                RUN;
  logic                STEP;
  logic [ADDR_W-1:0]   ROM_ADDR;
  logic [INSTR_W-1:0]  ROM_DATA;
  logic [DATA_W-1:0]   IN_PORT;
  logic [DATA_W-1:0]   OUT_PORT;
  logic [DATA_W-1:0]   REG_A;
  logic [DATA_W-1:0]   REG_B;
  logic                CARRY;
  logic                HALTED;
  logic                INSTR_DONE;

  modport master (
    input  RUN, STEP, ROM_DATA, IN_PORT,
    output ROM_ADDR, OUT_PORT, REG_A, REG_B, CARRY, HALTED, INSTR_DONE
  );

  modport slave (
    output RUN, STEP, ROM_DATA, IN_PORT,
    input  ROM_ADDR, OUT_PORT, REG_A, REG_B, CARRY, HALTED, INSTR_DONE
  );

endinterface

// File: rtl/td4_sequencer_decoder.sv
// Combinational TD4 opcode decoder; unlisted opcodes decode to an all-zero
// bundle, which the sequencer executes as a NOP.
module td4_decoder
  import td4_pkg::*;
(
  input  logic [3:0] i_op,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_op)
      OP_ADD_A:  begin o_ctrl.wrA = 1'b1; o_ctrl.src = SRC_A;  o_ctrl.addEn = 1'b1; end
      OP_ADD_B:  begin o_ctrl.wrB = 1'b1; o_ctrl.src = SRC_B;  o_ctrl.addEn = 1'b1; end
      OP_MOV_A:  begin o_ctrl.wrA = 1'b1; o_ctrl.src = SRC_IM; end
      OP_MOV_B:  begin o_ctrl.wrB = 1'b1; o_ctrl.src = SRC_IM; end
      OP_MOV_AB: begin o_ctrl.wrA = 1'b1; o_ctrl.src = SRC_B;  end
      OP_MOV_BA: begin o_ctrl.wrB = 1'b1; o_ctrl.src = SRC_A;  end
      OP_IN_A:   begin o_ctrl.wrA = 1'b1; o_ctrl.src = SRC_IN; end
      OP_IN_B:   begin o_ctrl.wrB = 1'b1; o_ctrl.src = SRC_IN; end
      OP_OUT_B:  begin o_ctrl.outEn = 1'b1; o_ctrl.src = SRC_B;  end
      OP_OUT_IM: begin o_ctrl.outEn = 1'b1; o_ctrl.src = SRC_IM; end
      OP_JMP:    begin o_ctrl.jump = 1'b1; end
      OP_JNC:    begin o_ctrl.jump = 1'b1; o_ctrl.jumpCond = 1'b1; end
      default:   o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/td4_sequencer.sv
// TD4 fetch/execute controller: drives the ROM address from PC, latches the
// instruction, and executes it against its own A/B/carry/output registers.
module td4_sequencer
  import td4_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC          = 4'h0,
  parameter bit                HALT_ON_SELF_JUMP = 1'b1,
  parameter bit                IN_SYNC           = 1'b1
) (
  input  logic              CLK,
  input  logic              N_RESET,
  td4_sequencer_if.master   bus
);

  state_e              r_state;
  state_e              w_nextState;
  logic [ADDR_W-1:0]   r_pc;
  logic [INSTR_W-1:0]  r_ir;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [DATA_W-1:0]   r_out;
  logic                r_carry;
  logic                r_halted;
  logic                r_done;
  logic                r_stepPrev;
  logic [DATA_W-1:0]   r_inMeta;
  logic [DATA_W-1:0]   r_inSync;

  ctrl_t               w_ctrl;
  logic [DATA_W-1:0]   w_im;
  logic [DATA_W-1:0]   w_inPort;
  logic [DATA_W-1:0]   w_src;
  logic [DATA_W:0]     w_sum;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_carryNext;
  logic                w_taken;
  logic                w_halt;
  logic [ADDR_W-1:0]   w_pcNext;
  logic                w_stepRise;

  assign w_im       = r_ir[3:0];
  assign w_inPort   = IN_SYNC ? r_inSync : bus.IN_PORT;
  assign w_stepRise = bus.STEP & ~r_stepPrev;

  td4_decoder u_decoder (
    .i_op   (r_ir[7:4]),
    .o_ctrl (w_ctrl)
  );

  always_comb begin
    w_src = w_im;
    case (w_ctrl.src)
      SRC_A:   w_src = r_a;
      SRC_B:   w_src = r_b;
      SRC_IN:  w_src = w_inPort;
      default: w_src = w_im;
    endcase
  end

  // JNC looks at the carry held from the previous instruction, not the new one.
  assign w_sum       = {1'b0, w_src} + {1'b0, w_im};
  assign w_wdata     = w_ctrl.addEn ? w_sum[DATA_W-1:0] : w_src;
  assign w_carryNext = w_ctrl.addEn & w_sum[DATA_W];
  assign w_taken     = w_ctrl.jump & (~w_ctrl.jumpCond | ~r_carry);
  assign w_pcNext    = w_taken ? w_im : r_pc + 4'd1;
  assign w_halt      = HALT_ON_SELF_JUMP && w_taken && (w_im == r_pc);

  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:  if (bus.RUN || w_stepRise) w_nextState = ST_FETCH;
      ST_FETCH: w_nextState = ST_EXEC;
      ST_EXEC: begin
        if (w_halt)       w_nextState = ST_HALT;
        else if (bus.RUN) w_nextState = ST_FETCH;
        else              w_nextState = ST_IDLE;
      end
      ST_HALT:  w_nextState = ST_HALT;
      default:  w_nextState = ST_IDLE;
    endcase
  end

  // The step detector samples every cycle so edges outside IDLE are lost.
  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      r_pc       <= RESET_PC;
      r_ir       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_out      <= '0;
      r_carry    <= 1'b0;
      r_halted   <= 1'b0;
      r_done     <= 1'b0;
      r_stepPrev <= 1'b0;
      r_inMeta   <= '0;
      r_inSync   <= '0;
    end else begin
      r_stepPrev <= bus.STEP;
      r_inMeta   <= bus.IN_PORT;
      r_inSync   <= r_inMeta;
      r_done     <= (r_state == ST_EXEC);
      if (r_state == ST_FETCH) begin
        r_ir <= bus.ROM_DATA;
      end
      if (r_state == ST_EXEC) begin
        r_pc    <= w_pcNext;
        r_carry <= w_carryNext;
        if (w_ctrl.wrA)   r_a      <= w_wdata;
        if (w_ctrl.wrB)   r_b      <= w_wdata;
        if (w_ctrl.outEn) r_out    <= w_wdata;
        if (w_halt)       r_halted <= 1'b1;
      end
    end
  end

  assign bus.ROM_ADDR   = r_pc;
  assign bus.OUT_PORT   = r_out;
  assign bus.REG_A      = r_a;
  assign bus.REG_B      = r_b;
  assign bus.CARRY      = r_carry;
  assign bus.HALTED     = r_halted;
  assign bus.INSTR_DONE = r_done;

endmodule
